// File: rtl/register_file.sv
// Architectural register file with ROB-tag renaming.
// Each architectural register holds a committed 32-bit value and the ROB tag
// of its youngest pending writer (tag 0 = value is current). Commits write
// values and retire the tag only if it still belongs to the committing entry,
// renames install new tags, and a flush wipes every pending tag at once.
// Reads are combinational and include a commit-to-read bypass so a source
// whose producer commits this very cycle is seen as ready with its result.
module register_file #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_res,
  input  logic [TAG_W-1:0] commit_dependency,
  input  logic             rename_valid,
  input  logic [4:0]       rename_rd,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag
);

  logic [31:0]      r_val [32];
  logic [TAG_W-1:0] r_tag [32];

  logic w_commit_we;
  logic w_rename_we;

  // Register 0 is excluded from both write paths; a flush cancels renames.
  assign w_commit_we = rdy && commit_valid && (commit_rd != 5'd0);
  assign w_rename_we = rdy && rename_valid && !flush && (rename_rd != 5'd0);

  // State update: reset wins, rdy low freezes everything, rename beats a
  // same-cycle tag clear, flush beats both for tags but not for values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < 32; i++) begin
        if (w_commit_we && (commit_rd == i[4:0])) begin
          r_val[i] <= commit_res;
        end
        if (flush) begin
          r_tag[i] <= '0;
        end else if (w_rename_we && (rename_rd == i[4:0])) begin
          r_tag[i] <= rename_tag;
        end else if (w_commit_we && (commit_rd == i[4:0]) &&
                     (r_tag[i] == commit_dependency)) begin
          r_tag[i] <= '0;
        end
      end
    end
  end

  logic [31:0]      w_rs1_val;
  logic [31:0]      w_rs2_val;
  logic [TAG_W-1:0] w_rs1_tag;
  logic [TAG_W-1:0] w_rs2_tag;

  // Read port 1: stored state, or the committing result when it resolves the pending tag.
  always_comb begin
    w_rs1_val = r_val[rs1];
    w_rs1_tag = r_tag[rs1];
    if (rs1 == 5'd0) begin
      w_rs1_val = '0;
      w_rs1_tag = '0;
    end else if ((r_tag[rs1] != '0) && rdy && commit_valid &&
                 (commit_rd == rs1) && (commit_dependency == r_tag[rs1])) begin
      w_rs1_val = commit_res;
      w_rs1_tag = '0;
    end
  end

  // Read port 2: identical to port 1, independent address.
  always_comb begin
    w_rs2_val = r_val[rs2];
    w_rs2_tag = r_tag[rs2];
    if (rs2 == 5'd0) begin
      w_rs2_val = '0;
      w_rs2_tag = '0;
    end else if ((r_tag[rs2] != '0) && rdy && commit_valid &&
                 (commit_rd == rs2) && (commit_dependency == r_tag[rs2])) begin
      w_rs2_val = commit_res;
      w_rs2_tag = '0;
    end
  end

  assign rs1_val = w_rs1_val;
  assign rs1_tag = w_rs1_tag;
  assign rs2_val = w_rs2_val;
  assign rs2_tag = w_rs2_tag;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: scenario tasks drive commits/renames/flushes,
// push the expected {value, tag} of each read into a queue, and pop and
// compare once the combinational read has settled.
module tb_register_file;

  localparam int TAG_W = 5;
  localparam int W     = 32 + TAG_W;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             flush;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_res;
  logic [TAG_W-1:0] commit_dependency;
  logic             rename_valid;
  logic [4:0]       rename_rd;
  logic [TAG_W-1:0] rename_tag;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      rs1_val;
  logic [31:0]      rs2_val;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;
  int checks;
  int errors;

  register_file #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_res(commit_res), .commit_dependency(commit_dependency),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 0; rdy = 1; flush = 0;
    commit_valid = 0; commit_rd = 0; commit_res = 0; commit_dependency = 0;
    rename_valid = 0; rename_rd = 0; rename_tag = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_commit(input logic [4:0] rd, input logic [31:0] res,
                              input logic [TAG_W-1:0] dep);
    commit_valid = 1; commit_rd = rd; commit_res = res; commit_dependency = dep;
  endtask

  task automatic drive_rename(input logic [4:0] rd, input logic [TAG_W-1:0] tag);
    rename_valid = 1; rename_rd = rd; rename_tag = tag;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      rs2 = 5'(31 - i);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      checks++; exp = exp_q.pop_front();
      if ({rs1_val, rs1_tag} !== exp) begin
        errors++;
        $display("FAIL reset rs1=%0d: got %h/%0d required %h/%0d", rs1, rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
      checks++; exp = exp_q.pop_front();
      if ({rs2_val, rs2_tag} !== exp) begin
        errors++;
        $display("FAIL reset rs2=%0d: got %h/%0d required %h/%0d", rs2, rs2_val, rs2_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
    end
  endtask

  task automatic test_rename_commit();
    idle();
    drive_rename(5, 3);
    rs1 = 5;
    exp_q.push_back({32'h0, 5'd0});      // rename not visible in its own cycle
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rename_same_cycle: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    step(); idle();
    exp_q.push_back({32'h0, 5'd3});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rename_pending: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    drive_commit(5, 32'h1234, 3);
    step(); idle();
    exp_q.push_back({32'h1234, 5'd0});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rename_commit: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
  endtask

  task automatic test_stale_commit();
    idle();
    drive_rename(7, 2); step();
    drive_rename(7, 4); step(); idle();
    drive_commit(7, 32'hAA, 2);
    rs1 = 7;
    exp_q.push_back({32'h0, 5'd4});      // dep mismatch: no bypass
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL stale_no_bypass: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    step(); idle();
    exp_q.push_back({32'hAA, 5'd4});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL stale_commit: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    drive_commit(7, 32'hBB, 4);
    step(); idle();
    exp_q.push_back({32'hBB, 5'd0});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL final_commit: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    drive_rename(9, 6); step(); idle();
    drive_commit(9, 32'h55, 6);
    rs1 = 9; rs2 = 9;
    rdy = 0;                             // bypass disabled while stalled
    exp_q.push_back({32'h0, 5'd6});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL bypass_rdy_low: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    step();                              // frozen edge
    rdy = 1;
    exp_q.push_back({32'h55, 5'd0});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs2_val, rs2_tag} !== exp) begin
      errors++;
      $display("FAIL bypass: got %h/%0d required %h/%0d", rs2_val, rs2_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    step(); idle();
    exp_q.push_back({32'h55, 5'd0});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs2_val, rs2_tag} !== exp) begin
      errors++;
      $display("FAIL bypass_after_edge: got %h/%0d required %h/%0d", rs2_val, rs2_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
  endtask

  task automatic test_rename_over_commit();
    idle();
    drive_rename(10, 8); step(); idle();
    drive_commit(10, 32'h77, 8);
    drive_rename(10, 9);
    rs1 = 10;
    exp_q.push_back({32'h77, 5'd0});     // pre-rename state plus bypass
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rename_commit_same_cycle_read: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    step(); idle();
    exp_q.push_back({32'h77, 5'd9});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rename_overrides_clear: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
  endtask

  task automatic test_flush();
    logic [4:0] regs [4];
    idle();
    drive_rename(1, 1); step();
    drive_rename(2, 2); step();
    drive_rename(3, 3); step(); idle();
    flush = 1;
    drive_commit(1, 32'h10, 1);
    drive_rename(4, 5);
    step(); idle();
    regs[0] = 1; regs[1] = 2; regs[2] = 3; regs[3] = 4;
    exp_q.push_back({32'h10, 5'd0});
    exp_q.push_back({32'h0, 5'd0});
    exp_q.push_back({32'h0, 5'd0});
    exp_q.push_back({32'h0, 5'd0});
    for (int i = 0; i < 4; i++) begin
      rs2 = regs[i];
      #1;
      checks++; exp = exp_q.pop_front();
      if ({rs2_val, rs2_tag} !== exp) begin
        errors++;
        $display("FAIL flush x%0d: got %h/%0d required %h/%0d", rs2, rs2_val, rs2_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
    end
  endtask

  task automatic test_x0_and_rdy();
    idle();
    drive_rename(0, 7);
    drive_commit(0, 32'hFFFF, 0);
    step(); idle();
    rs1 = 0;
    exp_q.push_back('0);
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL x0: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    rdy = 0;
    drive_rename(6, 7);
    drive_commit(6, 32'h66, 0);
    step();
    rdy = 1; rename_valid = 0; commit_valid = 0;
    rs1 = 6;
    exp_q.push_back({32'h0, 5'd0});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rdy_low_frozen: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
    drive_rename(6, 7);
    step(); idle();
    exp_q.push_back({32'h0, 5'd7});
    #1;
    checks++; exp = exp_q.pop_front();
    if ({rs1_val, rs1_tag} !== exp) begin
      errors++;
      $display("FAIL rdy_high_applies: got %h/%0d required %h/%0d", rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m_val [32];
    logic [4:0]  prev_rd;
    logic [4:0]  rd;
    logic [31:0] res;
    idle();
    flush = 1;                           // clear all pending tags
    step(); idle();
    for (int i = 0; i < 32; i++) m_val[i] = 32'h0;
    m_val[1] = 32'h10; m_val[5] = 32'h1234; m_val[7] = 32'hBB;
    m_val[9] = 32'h55; m_val[10] = 32'h77;
    prev_rd = 5'd1;
    for (int n = 0; n < 40; n++) begin
      rd  = 5'($urandom_range(1, 31));
      res = $urandom;
      drive_commit(rd, res, 0);
      rs1 = prev_rd;
      exp_q.push_back({m_val[prev_rd], 5'd0});
      #1;
      checks++; exp = exp_q.pop_front();
      if ({rs1_val, rs1_tag} !== exp) begin
        errors++;
        $display("FAIL back_to_back x%0d: got %h/%0d required %h/%0d", rs1, rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
      m_val[rd] = res;
      prev_rd = rd;
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      rs2 = i[4:0];
      exp_q.push_back({m_val[i], 5'd0});
      #1;
      checks++; exp = exp_q.pop_front();
      if ({rs2_val, rs2_tag} !== exp) begin
        errors++;
        $display("FAIL readback x%0d: got %h/%0d required %h/%0d", rs2, rs2_val, rs2_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    drive_rename(11, 12); step();
    drive_rename(12, 13); step(); idle();
    rst = 1; flush = 1;
    drive_commit(11, 32'hDEAD, 12);
    drive_rename(13, 14);
    step(); idle();
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      exp_q.push_back('0);
      #1;
      checks++; exp = exp_q.pop_front();
      if ({rs1_val, rs1_tag} !== exp) begin
        errors++;
        $display("FAIL reset_mid x%0d: got %h/%0d required %h/%0d", rs1, rs1_val, rs1_tag, exp[W-1:TAG_W], exp[TAG_W-1:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rs1 = 0; rs2 = 0;
    idle();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_bypass();
    test_rename_over_commit();
    test_flush();
    test_x0_and_rdy();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter TAG_W, default 5, ROB tag width; tag 0 means "no pending writer"; valid tags are 1..2^TAG_W-1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port rdy, input, 1, global enable; state is frozen when low.
REQ-005 SHALL have port flush, input, 1, mispredict flush, driven by the ROB's wrong_commit.
REQ-006 SHALL have port commit_valid, input, 1, ROB commit strobe.
REQ-007 SHALL have port commit_rd, input, 5, committed architectural destination.
REQ-008 SHALL have port commit_res, input, 32, committed value.
REQ-009 SHALL have port commit_dependency, input, TAG_W, ROB tag of the committing entry.
REQ-010 SHALL have port rename_valid, input, 1, dispatch-side rename request.
REQ-011 SHALL have port rename_rd, input, 5, architectural register being renamed.
REQ-012 SHALL have port rename_tag, input, TAG_W, ROB tag allocated by the ROB (its rename_rd).
REQ-013 SHALL have ports rs1 and rs2, input, 5 each, read addresses.
REQ-014 SHALL have ports rs1_val and rs2_val, output, 32 each, operand values.
REQ-015 SHALL have ports rs1_tag and rs2_tag, output, TAG_W each, pending ROB tag; 0 means the value is valid.

Function
REQ-016 SHALL hold 32 x 32-bit value registers and 32 x TAG_W tag registers.
REQ-017 SHALL perform a commit write when rdy and commit_valid are high and commit_rd is not 0: the value register at commit_rd takes commit_res.
REQ-018 SHALL, on a commit write, clear tag[commit_rd] to 0 only if it equals commit_dependency; a younger rename is kept.
REQ-019 SHALL perform a rename when rdy and rename_valid are high, rename_rd is not 0, and flush is low: tag[rename_rd] takes rename_tag.
REQ-020 SHALL let a rename override a same-cycle commit tag-clear on the same register; the commit value write still occurs.
REQ-021 SHALL, when rdy and flush are high, set all 32 tags to 0 next edge, still apply any same-cycle commit value write, and drop any rename.
REQ-022 SHALL never change register 0; reads of 0 return value 0 and tag 0.
REQ-023 SHALL produce reads combinationally, with zero latency, on each port independently.
REQ-024 SHALL, when tag[rs] is 0, output value reg[rs] and tag 0.
REQ-025 SHALL, when tag[rs] is not 0, output value reg[rs] and tag tag[rs].
REQ-026 SHALL apply a bypass when tag[rs] is not 0, rdy and commit_valid are high, commit_rd equals rs, and commit_dependency equals tag[rs]: output value commit_res and tag 0.
REQ-027 SHALL return the pre-rename state on reads; a same-cycle rename is not visible. The dispatcher reads sources before renaming rd.
REQ-028 SHALL make no state change while rdy is low, including under flush, commit or rename; bypass is also disabled.

Reset
REQ-029 SHALL, when rst is high at a clock edge, clear all value and tag registers to 0 regardless of rdy, flush or other inputs.
REQ-030 SHALL give rst priority over any same-cycle commit, rename or flush.
REQ-031 SHALL make all outputs read 0 for any rs in the cycle after reset, since all outputs are derived from the cleared state.

Verification
REQ-032 Rename then commit: rename x5 to tag 3; next cycle commit rd=5, res=0x1234, dep=3 -> after the commit edge rs1=5 gives val 0x1234, tag 0.
REQ-033 Stale commit: rename x7 to tag 2, then rename x7 to tag 4; commit rd=7, dep=2, res=0xAA -> reg[7]=0xAA and tag stays 4; commit dep=4, res=0xBB -> tag 0, val 0xBB.
REQ-034 Bypass: tag[x9]=6 and commit rd=9, dep=6, res=0x55 in the same cycle -> rs2=9 gives val 0x55, tag 0 combinationally, before the edge.
REQ-035 Flush: x1, x2 and x3 renamed to tags 1, 2, 3; flush with commit rd=1, dep=1, res=0x10 and rename x4 to tag 5 -> all tags 0, reg[1]=0x10, x4 tag 0.
REQ-036 x0 and rdy: rename or commit to x0 -> rs1=0 reads 0/0; with rdy low, rename x6 to tag 7 -> tag[6] unchanged; with rdy high again it applies.
REQ-037 Reset mid-operation: with several tags pending, assert rst together with commit and rename -> all registers and tags read 0 next cycle.
